// File: rtl/vram_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : vram_rect_fill
//  Description : VRAM write-side rectangle fill engine. Accepts one
//                rectangle-fill command at a time, clips it to the
//                H_RES x V_RES frame and writes the fill colour to every
//                covered pixel in row-major order (addr = col + H_RES*row).
//
//  Ports       : clk          system clock, all logic on the rising edge
//                rst_n        synchronous active-low reset
//                cmd_valid    command present
//                cmd_ready    engine idle and able to accept a command
//                cmd_x/cmd_y  top-left corner (column / row)
//                cmd_w/cmd_h  width / height in pixels
//                cmd_color    fill colour (RGB444)
//                cmd_outline  (RECT_OUTLINE_EN only) draw perimeter only
//                vram_we      write request
//                vram_addr    write address
//                vram_wdata   write data
//                vram_wready  VRAM accepts the write this cycle
//                busy         a command is in progress
//                done         one-cycle pulse when a command completes
//
//  Build option: define RECT_OUTLINE_EN to add the cmd_outline input and
//                the perimeter-only drawing mode.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_rect_fill #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
`ifdef RECT_OUTLINE_EN
    input  logic              cmd_outline,
`endif
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic              vram_wready,
    output logic              busy,
    output logic              done
);

    // Frame limits widened to the 11-bit clip arithmetic width.
    localparam logic [10:0]       c_H_RES_W  = 11'(H_RES);
    localparam logic [10:0]       c_V_RES_W  = 11'(V_RES);
    localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Command decode and clipping (evaluated on the accept cycle only)
    // ------------------------------------------------------------------
    logic        w_accept;
    logic [10:0] w_x_sum;
    logic [10:0] w_y_sum;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_empty;

    assign cmd_ready = (r_state == ST_IDLE) && rst_n;
    assign w_accept  = cmd_valid && cmd_ready;

    assign w_x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign w_y_sum = {2'b00, cmd_y} + {2'b00, cmd_h};
    assign w_x_end = (w_x_sum > c_H_RES_W) ? c_H_RES_W : w_x_sum;
    assign w_y_end = (w_y_sum > c_V_RES_W) ? c_V_RES_W : w_y_sum;

    assign w_empty = (cmd_w == 10'd0) || (cmd_h == 9'd0) ||
                     ({1'b0, cmd_x} >= c_H_RES_W) ||
                     ({2'b00, cmd_y} >= c_V_RES_W);

    // ------------------------------------------------------------------
    // Latched command and walk registers
    // ------------------------------------------------------------------
    logic [9:0]        r_x0;
    logic [8:0]        r_y0;
    logic [9:0]        r_x_last;   // last column to write (inclusive)
    logic [8:0]        r_y_last;   // last row to write (inclusive)
    logic [DATA_W-1:0] r_color;
    logic [9:0]        r_col;
    logic [8:0]        r_row;
    logic [ADDR_W-1:0] r_row_base; // r_row * H_RES, tracked incrementally
    logic              w_outline;

`ifdef RECT_OUTLINE_EN
    logic r_outline;
    assign w_outline = r_outline;
`else
    assign w_outline = 1'b0;
`endif

    logic w_wr_fire;
    logic w_col_last;
    logic w_row_last;
    logic w_row_interior;

    assign w_wr_fire      = (r_state == ST_WRITE) && vram_wready;
    assign w_col_last     = (r_col == r_x_last);
    assign w_row_last     = (r_row == r_y_last);
    assign w_row_interior = (r_row != r_y0) && !w_row_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_x_last   <= '0;
            r_y_last   <= '0;
            r_color    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else begin
            if (w_accept) begin
                r_x0     <= cmd_x;
                r_y0     <= cmd_y;
                // Only meaningful for non-empty commands, where the clipped
                // end is always at least one past the start.
                r_x_last <= 10'(w_x_end - 11'd1);
                r_y_last <= 9'(w_y_end - 11'd1);
                r_color  <= cmd_color;
            end

            if (r_state == ST_SETUP) begin
                // One constant multiply per command; rows after the first
                // advance the base by a plain add.
                r_row_base <= ADDR_W'(r_y0) * c_ROW_STEP;
                r_col      <= r_x0;
                r_row      <= r_y0;
            end

            if (w_wr_fire) begin
                if (w_col_last) begin
                    if (!w_row_last) begin
                        r_col      <= r_x0;
                        r_row      <= r_row + 9'd1;
                        r_row_base <= r_row_base + c_ROW_STEP;
                    end
                end else if (w_outline && w_row_interior && (r_col == r_x0)) begin
                    // Interior outline row: skip straight to the right edge.
                    r_col <= r_x_last;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

`ifdef RECT_OUTLINE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outline <= 1'b0;
        end else if (w_accept) begin
            r_outline <= cmd_outline;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        vram_we     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = w_empty ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                vram_we = 1'b1;
                if (vram_wready && w_col_last && w_row_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address and data come straight from registers, so they stay stable
    // for as long as the VRAM holds off the write.
    assign vram_addr  = r_row_base + ADDR_W'(r_col);
    assign vram_wdata = r_color;

endmodule
`default_nettype wire

// File: tb/tb_vram_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_rect_fill
//  Description : Self-checking bench for vram_rect_fill. Expected writes are
//                queued when a command is issued and compared in order as
//                the engine performs write handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_rect_fill;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int TMO    = 20000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x;
    logic [8:0]        cmd_y;
    logic [9:0]        cmd_w;
    logic [8:0]        cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic              cmd_outline;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_wdata;
    logic              vram_wready;
    logic              busy;
    logic              done;

    vram_rect_fill #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
`ifdef RECT_OUTLINE_EN
        .cmd_outline(cmd_outline),
`endif
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_wready(vram_wready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // Scoreboard: {addr, data}
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    int wr_cnt, stall_cnt, done_cnt, first_we_cyc, last_wr_cyc;
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;

    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (done) done_cnt++;
        if (vram_we && first_we_cyc < 0) first_we_cyc = cyc;
        if (vram_we && prev_stall) begin
            total++;
            if (vram_addr !== prev_addr || vram_wdata !== prev_data) begin
                bad++;
                $display("FAIL stall_hold: addr=%0d data=%h required addr=%0d data=%h",
                         vram_addr, vram_wdata, prev_addr, prev_data);
            end
        end
        if (vram_we && !vram_wready) stall_cnt++;
        if (vram_we && vram_wready) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0d data=%h required no write",
                         vram_addr, vram_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({vram_addr, vram_wdata} !== e) begin
                    bad++;
                    $display("FAIL write: addr=%0d data=%h required addr=%0d data=%h",
                             vram_addr, vram_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
        prev_stall = vram_we && !vram_wready && rst_n;
        prev_addr  = vram_addr;
        prev_data  = vram_wdata;
    end

    task automatic clear_stats();
        @(posedge clk);
        #1;
        wr_cnt       = 0;
        stall_cnt    = 0;
        done_cnt     = 0;
        first_we_cyc = -1;
        last_wr_cyc  = -1;
    endtask

    // Independent reference: clip, then enumerate pixels in row-major order.
    task automatic push_rect(input int x, input int y, input int w, input int h,
                             input logic [DATA_W-1:0] col, input bit outline);
        int xe, ye;
        logic [ADDR_W-1:0] a;
        if (w == 0 || h == 0 || x >= H_RES || y >= V_RES) return;
        xe = (x + w > H_RES) ? H_RES : x + w;
        ye = (y + h > V_RES) ? V_RES : y + h;
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                if (!outline || r == y || r == ye - 1 || c == x || c == xe - 1) begin
                    a = ADDR_W'(r * H_RES + c);
                    exp_q.push_back({a, col});
                end
    endtask

    // Issues one command; returns the accept cycle index (-1 on timeout).
    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input logic [DATA_W-1:0] col, input bit outline,
                            output int t_acc);
        int n = 0;
        t_acc = -1;
        @(negedge clk);
        while (!cmd_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) return;
        cmd_valid   = 1'b1;
        cmd_x       = 10'(x);
        cmd_y       = 9'(y);
        cmd_w       = 10'(w);
        cmd_h       = 9'(h);
        cmd_color   = col;
        cmd_outline = outline;
        t_acc       = cyc;
        @(posedge clk);
        #1;
        // Scramble inputs: the engine must use its latched copy.
        cmd_valid   = 1'b0;
        cmd_x       = 10'($urandom);
        cmd_y       = 9'($urandom);
        cmd_w       = 10'($urandom);
        cmd_h       = 9'($urandom);
        cmd_color   = 12'($urandom);
        cmd_outline = 1'($urandom);
    endtask

    // Waits for the done pulse; returns its cycle index (-1 on timeout).
    task automatic wait_done(output int t_done);
        int n = 0;
        t_done = -1;
        while (n < TMO) begin
            @(negedge clk);
            if (done) begin
                t_done = cyc;
                break;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({vram_we, busy, done, cmd_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: we/busy/done/ready=%b required 0000",
                     {vram_we, busy, done, cmd_ready});
        end
        total++;
        if (vram_addr !== '0 || vram_wdata !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d data=%h required 0/000", vram_addr, vram_wdata);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic_fill();
        int ta, td;
        clear_stats();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back({ADDR_W'(3210 + 640 * r + c), 12'hF00});
        send_cmd(10, 5, 4, 2, 12'hF00, 1'b0, ta);
        wait_done(td);
        total++;
        if (ta < 0 || td < 0) begin
            bad++;
            $display("FAIL basic_timeout: accept=%0d done=%0d required both seen", ta, td);
        end
        total++;
        if (first_we_cyc != ta + 2) begin
            bad++;
            $display("FAIL basic_first_we: cycle=%0d required %0d", first_we_cyc, ta + 2);
        end
        total++;
        if (td != last_wr_cyc + 1) begin
            bad++;
            $display("FAIL basic_done_latency: cycle=%0d required %0d", td, last_wr_cyc + 1);
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready_after_done: ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        total++;
        if (wr_cnt != 8 || exp_q.size() != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL basic_counts: writes=%0d left=%0d dones=%0d required 8 0 1",
                     wr_cnt, exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_clip();
        int ta, td;
        clear_stats();
        exp_q.push_back({19'd307198, 12'h0A5});
        exp_q.push_back({19'd307199, 12'h0A5});
        send_cmd(638, 479, 5, 3, 12'h0A5, 1'b0, ta);
        wait_done(td);
        @(negedge clk);
        total++;
        if (td < 0 || wr_cnt != 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL clip: done=%0d writes=%0d left=%0d required done seen, 2, 0",
                     td, wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_empty();
        int ta, td;
        int xs[2] = '{5, 700};
        int ws[2] = '{0, 10};
        for (int i = 0; i < 2; i++) begin
            clear_stats();
            send_cmd(xs[i], 0, ws[i], 10, 12'h123, 1'b0, ta);
            wait_done(td);
            total++;
            if (ta < 0 || td != ta + 1) begin
                bad++;
                $display("FAIL empty_done_%0d: cycle=%0d required %0d", i, td, ta + 1);
            end
            @(negedge clk);
            total++;
            if (first_we_cyc != -1 || wr_cnt != 0) begin
                bad++;
                $display("FAIL empty_writes_%0d: writes=%0d first_we=%0d required none",
                         i, wr_cnt, first_we_cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int ta, td, n;
        clear_stats();
        push_rect(100, 10, 8, 1, 12'h3C7, 1'b0);
        send_cmd(100, 10, 8, 1, 12'h3C7, 1'b0, ta);
        n = 0;
        while (wr_cnt < 3 && n < TMO) begin
            @(posedge clk);
            n++;
        end
        #1 vram_wready = 1'b0;
        repeat (3) @(posedge clk);
        #1 vram_wready = 1'b1;
        wait_done(td);
        @(negedge clk);
        total++;
        if (td < 0 || stall_cnt != 3) begin
            bad++;
            $display("FAIL bp_stall: done=%0d stalls=%0d required done seen, 3", td, stall_cnt);
        end
        total++;
        if (wr_cnt != 8 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_counts: writes=%0d left=%0d required 8 0", wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int ta, td, n, dones_before;
        clear_stats();
        push_rect(0, 0, 100, 100, 12'hABC, 1'b0);
        send_cmd(0, 0, 100, 100, 12'hABC, 1'b0, ta);
        n = 0;
        while (wr_cnt < 50 && n < TMO) begin
            @(posedge clk);
            n++;
        end
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (vram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abort: we=%b busy=%b done=%b required 0 0 0",
                     vram_we, busy, done);
        end
        exp_q.delete();
        dones_before = done_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || done_cnt != dones_before) begin
            bad++;
            $display("FAIL midreset_release: ready=%b extra_dones=%0d required 1 0",
                     cmd_ready, done_cnt - dones_before);
        end
        clear_stats();
        push_rect(5, 7, 2, 2, 12'h5A5, 1'b0);
        send_cmd(5, 7, 2, 2, 12'h5A5, 1'b0, ta);
        wait_done(td);
        @(negedge clk);
        total++;
        if (td < 0 || wr_cnt != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_refill: done=%0d writes=%0d left=%0d required done seen, 4, 0",
                     td, wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ta, td;
        clear_stats();
        push_rect(630, 0, 20, 2, 12'h00F, 1'b0);
        push_rect(3, 478, 2, 9, 12'hFFF, 1'b0);
        send_cmd(630, 0, 20, 2, 12'h00F, 1'b0, ta);
        send_cmd(3, 478, 2, 9, 12'hFFF, 1'b0, ta);
        wait_done(td);
        @(negedge clk);
        total++;
        if (td < 0 || wr_cnt != 24 || exp_q.size() != 0 || done_cnt != 2) begin
            bad++;
            $display("FAIL b2b: writes=%0d left=%0d dones=%0d required 24 0 2",
                     wr_cnt, exp_q.size(), done_cnt);
        end
    endtask

`ifdef RECT_OUTLINE_EN
    task automatic test_outline();
        int ta, td;
        int addrs[10] = '{0, 1, 2, 3, 640, 643, 1280, 1281, 1282, 1283};
        clear_stats();
        foreach (addrs[i]) exp_q.push_back({ADDR_W'(addrs[i]), 12'h0F0});
        send_cmd(0, 0, 4, 3, 12'h0F0, 1'b1, ta);
        wait_done(td);
        @(negedge clk);
        total++;
        if (td < 0 || wr_cnt != 10 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL outline: writes=%0d left=%0d required 10 0", wr_cnt, exp_q.size());
        end
        total++;
        if (last_wr_cyc - first_we_cyc != 9) begin
            bad++;
            $display("FAIL outline_no_gaps: span=%0d required 9", last_wr_cyc - first_we_cyc);
        end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_x       = '0;
        cmd_y       = '0;
        cmd_w       = '0;
        cmd_h       = '0;
        cmd_color   = '0;
        cmd_outline = 1'b0;
        vram_wready = 1'b1;
        wr_cnt       = 0;
        stall_cnt    = 0;
        done_cnt     = 0;
        first_we_cyc = -1;
        last_wr_cyc  = -1;

        test_reset();
        test_basic_fill();
        test_clip();
        test_empty();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
`ifdef RECT_OUTLINE_EN
        test_outline();
`endif
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
